// File: rtl/zero_count_gen_pkg.sv
// Shared types and helpers for the zero-count pattern generator.
package zero_count_gen_pkg;

    typedef enum logic {ST_IDLE, ST_SHIFT} zcg_state_t;

    localparam int THERM_MAX_W = 64;

    function automatic int stream_len(input int bits);
        return 2 * bits;
    endfunction

    // Low `len` bits zero, bits len..width-1 one, anything above width zero.
    function automatic logic [THERM_MAX_W-1:0] therm(input int len, input int width);
        logic [THERM_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < THERM_MAX_W; i++)
            r[i] = (i >= len) && (i < width);
        return r;
    endfunction

endpackage

// File: rtl/zero_count_gen_therm.sv
// Combinational zero count -> {word2, word1} pattern (word1 in the low half).
module zero_count_gen_therm
    import zero_count_gen_pkg::*;
#(
    parameter int BITS = 3
) (
    input  logic [BITS:0]     n,
    output logic [2*BITS-1:0] pattern
);

    localparam int LEN = stream_len(BITS);

    assign pattern = LEN'(therm(int'(n), LEN));

endmodule

// File: rtl/zero_count_gen.sv
// Serial zero-pattern generator: request a zero count, stream 2*BITS bits out.
// Define ZERO_COUNT_GEN_PARALLEL_EN to also expose the two words in parallel.
module zero_count_gen
    import zero_count_gen_pkg::*;
#(
    parameter int BITS = 3
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [BITS-1:0] i_count,
    output logic            o_ser_valid,
    output logic            o_ser_data,
    output logic            o_ser_last,
    input  logic            i_ser_ready,
    output logic            o_clamp,
    output logic            o_busy
`ifdef ZERO_COUNT_GEN_PARALLEL_EN
    ,
    output logic [BITS-1:0] o_word1,
    output logic [BITS-1:0] o_word2,
    output logic            o_word_valid
`endif
);

    localparam int LEN = stream_len(BITS);
    localparam int KW  = $clog2(LEN);
    localparam logic [BITS+1:0] LEN_CMP = (BITS+2)'(LEN);
    localparam logic [BITS:0]   LEN_N   = (BITS+1)'(LEN);
    localparam logic [KW-1:0]   K_LAST  = KW'(LEN - 1);
    localparam logic [KW-1:0]   K_PEN   = KW'(LEN - 2);

    zcg_state_t      state;
    logic [KW-1:0]   k;
    logic [LEN-1:0]  sreg;
    logic            ser_data_q;
    logic            ser_last_q;
    logic            clamp_q;

    logic            accept;
    logic            over;
    logic [BITS:0]   n;
    logic [LEN-1:0]  pattern;

    assign accept = i_valid && (state == ST_IDLE);
    assign over   = {2'b00, i_count} > LEN_CMP;
    assign n      = over ? LEN_N : {1'b0, i_count};

    zero_count_gen_therm #(.BITS(BITS)) u_therm (
        .n       (n),
        .pattern (pattern)
    );

    // The whole pattern is captured at accept; the output bit comes from a
    // flop so i_ser_ready never reaches an output combinationally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            k          <= '0;
            sreg       <= '0;
            ser_data_q <= 1'b0;
            ser_last_q <= 1'b0;
            clamp_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state      <= ST_SHIFT;
                        k          <= '0;
                        sreg       <= pattern;
                        ser_data_q <= pattern[0];
                        ser_last_q <= 1'b0;
                        clamp_q    <= over;
                    end
                end
                ST_SHIFT: begin
                    if (i_ser_ready) begin
                        if (k == K_LAST) begin
                            state      <= ST_IDLE;
                            k          <= '0;
                            ser_data_q <= 1'b0;
                            ser_last_q <= 1'b0;
                        end else begin
                            k          <= k + 1'b1;
                            sreg       <= sreg >> 1;
                            ser_data_q <= sreg[1];
                            ser_last_q <= (k == K_PEN);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_ready     = (state == ST_IDLE);
    assign o_busy      = (state == ST_SHIFT);
    assign o_ser_valid = (state == ST_SHIFT);
    assign o_ser_data  = ser_data_q;
    assign o_ser_last  = ser_last_q;
    assign o_clamp     = clamp_q;

`ifdef ZERO_COUNT_GEN_PARALLEL_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_word1      <= '1;
            o_word2      <= '1;
            o_word_valid <= 1'b0;
        end else begin
            o_word_valid <= accept;
            if (accept) begin
                o_word1 <= pattern[BITS-1:0];
                o_word2 <= pattern[LEN-1:BITS];
            end
        end
    end
`endif

endmodule

// File: tb/tb_zero_count_gen.sv
// Directed scoreboard bench for zero_count_gen (BITS=3).
module tb_zero_count_gen;

    localparam int BITS = 3;
    localparam int LEN  = 2 * BITS;

    logic            i_clk = 1'b0;
    logic            i_rst_n;
    logic            i_valid = 1'b0;
    logic [BITS-1:0] i_count = '0;
    logic            i_ser_ready = 1'b0;
    logic            o_ready, o_ser_valid, o_ser_data, o_ser_last, o_clamp, o_busy;
`ifdef ZERO_COUNT_GEN_PARALLEL_EN
    logic [BITS-1:0] o_word1, o_word2;
    logic            o_word_valid;
    int              pulses = 0;
`endif

    always #5 i_clk = ~i_clk;

    zero_count_gen #(.BITS(BITS)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_count     (i_count),
        .o_ser_valid (o_ser_valid),
        .o_ser_data  (o_ser_data),
        .o_ser_last  (o_ser_last),
        .i_ser_ready (i_ser_ready),
        .o_clamp     (o_clamp),
        .o_busy      (o_busy)
`ifdef ZERO_COUNT_GEN_PARALLEL_EN
        ,
        .o_word1     (o_word1),
        .o_word2     (o_word2),
        .o_word_valid(o_word_valid)
`endif
    );

    typedef struct packed {
        logic d;
        logic last;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LEN-1:0] model_pattern(input int c);
        logic [LEN-1:0] p;
        int nz;
        nz = (c > LEN) ? LEN : c;
        for (int b = 0; b < LEN; b++)
            p[b] = (b >= nz);
        return p;
    endfunction

    task automatic push_exp(input int c);
        logic [LEN-1:0] p;
        exp_t e;
        p = model_pattern(c);
        for (int b = 0; b < LEN; b++) begin
            e.d    = p[b];
            e.last = (b == LEN - 1);
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Serial-side monitor: pops on each handshake, checks stalled bits hold.
    initial begin
        logic held_v, held_d, held_l;
        exp_t e;
        held_v = 1'b0;
        held_d = 1'b0;
        held_l = 1'b0;
        forever begin
            @(negedge i_clk);
            if (i_rst_n && o_ser_valid) begin
                if (held_v) begin
                    chk("hold_data", o_ser_data, held_d);
                    chk("hold_last", o_ser_last, held_l);
                end
                if (i_ser_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_bit_sb_size", sb.size(), 1);
                    end else begin
                        e = sb.pop_front();
                        chk("ser_data", o_ser_data, e.d);
                        chk("ser_last", o_ser_last, e.last);
                    end
                    held_v = 1'b0;
                end else begin
                    held_v = 1'b1;
                    held_d = o_ser_data;
                    held_l = o_ser_last;
                end
            end else begin
                held_v = 1'b0;
            end
        end
    end

`ifdef ZERO_COUNT_GEN_PARALLEL_EN
    initial forever begin
        @(negedge i_clk);
        if (o_word_valid) pulses++;
    end
`endif

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, o_ready, 1);
        chk({tag, "_ser_valid"}, o_ser_valid, 0);
        chk({tag, "_ser_data"}, o_ser_data, 0);
        chk({tag, "_ser_last"}, o_ser_last, 0);
        chk({tag, "_clamp"}, o_clamp, 0);
        chk({tag, "_busy"}, o_busy, 0);
`ifdef ZERO_COUNT_GEN_PARALLEL_EN
        chk({tag, "_word1"}, o_word1, 3'b111);
        chk({tag, "_word2"}, o_word2, 3'b111);
        chk({tag, "_word_valid"}, o_word_valid, 0);
`endif
    endtask

    task automatic send(input int c, input bit exp_clamp, input bit hold);
        int w;
        logic [LEN-1:0] p;
        p = model_pattern(c);
        i_count = c[BITS-1:0];
        i_valid = 1'b1;
        w = 0;
        while (!o_ready && w < 50) begin
            tick();
            w++;
        end
        chk("ready_before_accept", o_ready, 1);
`ifdef ZERO_COUNT_GEN_PARALLEL_EN
        pulses = 0;
`endif
        push_exp(c);
        tick();
        if (!hold) i_valid = 1'b0;
        chk("accept_ready_low", o_ready, 0);
        chk("accept_busy", o_busy, 1);
        chk("accept_ser_valid", o_ser_valid, 1);
        chk("accept_clamp", o_clamp, exp_clamp);
`ifdef ZERO_COUNT_GEN_PARALLEL_EN
        chk("word_valid", o_word_valid, 1);
        chk("word1", o_word1, p[BITS-1:0]);
        chk("word2", o_word2, p[LEN-1:BITS]);
`endif
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (!o_ready && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("idle_reached", o_ready, 1);
    endtask

    initial begin
        int cyc;
        int j;
        bit seen;

        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        check_reset_vals("reset");
        #2;
        i_rst_n = 1'b1;
        tick();

        // count 0: all ones, transaction edge count
        i_ser_ready = 1'b1;
        send(0, 1'b0, 1'b0);
        wait_idle(cyc);
        chk("count0_edges_to_ready", cyc, LEN);
        chk("count0_sb_empty", sb.size(), 0);
`ifdef ZERO_COUNT_GEN_PARALLEL_EN
        chk("count0_pulses", pulses, 1);
`endif

        // count 4
        send(4, 1'b0, 1'b0);
        wait_idle(cyc);
        chk("count4_sb_empty", sb.size(), 0);
`ifdef ZERO_COUNT_GEN_PARALLEL_EN
        chk("count4_pulses", pulses, 1);
`endif

        // count 7 saturates to 6 zeros; clamp holds while idle
        send(7, 1'b1, 1'b0);
        wait_idle(cyc);
        chk("count7_sb_empty", sb.size(), 0);
        tick();
        chk("count7_clamp_hold", o_clamp, 1);

        // count 2 with stalls 1,0,0,1,...
        send(2, 1'b0, 1'b0);
        j = 0;
        while (!o_ready && j < 100) begin
            i_ser_ready = (j % 4 == 0) || (j % 4 == 3);
            tick();
            j++;
        end
        chk("stall_idle", o_ready, 1);
        chk("stall_sb_empty", sb.size(), 0);
        i_ser_ready = 1'b1;

        // reset in the middle of a count 5 stream, then count 1
        send(5, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        chk("midreset_bits_left", sb.size(), 3);
        i_rst_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        sb.delete();
        #2;
        i_rst_n = 1'b1;
        tick();
        tick();
        chk("midreset_no_resume", o_ser_valid, 0);
        send(1, 1'b0, 1'b0);
        wait_idle(cyc);
        chk("count1_sb_empty", sb.size(), 0);

        // back-to-back with i_valid held: 6 then 1
        send(6, 1'b0, 1'b1);
        i_count = 3'd1;
        push_exp(1);
        j = 0;
        seen = 1'b0;
        while (!seen && j < 50) begin
            chk("b2b_no_early_accept", o_ready, 0);
            if (o_ser_last && i_ser_ready) seen = 1'b1;
            tick();
            j++;
        end
        chk("b2b_last_seen", seen, 1);
        chk("b2b_ready_after_last", o_ready, 1);
        tick();
        i_valid = 1'b0;
        chk("b2b_second_accept", o_busy, 1);
        chk("b2b_second_clamp", o_clamp, 0);
        wait_idle(cyc);
        chk("b2b_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/zero_count_gen.md
# zero_count_gen

Serial zero-pattern generator, the producing end of the team's zero-count path. It accepts a requested zero count over a valid/ready handshake. It then streams out a 2*BITS-bit pattern, logically two BITS-wide words, containing exactly that many zeros, with backpressure on the serial side. It is used as the source that feeds words into the zero counters and to generate self-checking stimulus for them.

## Interface
- BITS, 3, width of each word and of the requested count
- i_clk  input  1  clock, all state on rising edge
- i_rst_n  input  1  reset, asynchronous assert, active-low
- i_valid  input  1  request valid
- o_ready  output  1  block can accept a request (IDLE)
- i_count  input  BITS  requested number of zeros
- o_ser_valid  output  1  serial bit valid
- o_ser_data  output  1  current pattern bit
- o_ser_last  output  1  marks bit 2*BITS-1
- i_ser_ready  input  1  sink accepts current bit
- o_clamp  output  1  current/last request exceeded 2*BITS and was saturated
- o_busy  output  1  transaction in progress (SHIFT)

## Operation
- Request handshake: the request is accepted on a cycle where i_valid && o_ready.
- o_ready is 1 only in IDLE.
- On accept, latch n = min(i_count, 2*BITS) and set o_clamp = (i_count > 2*BITS).
  - Compare in BITS+2 bits.
  - For BITS<=2, 2^BITS-1 < 2*BITS + 1, so o_clamp never sets.
- Pattern bit k, for k = 0..2*BITS-1, is 0 if k < n, else 1.
  - Bit order: word1 bit0..bit BITS-1, then word2 bit0..bit BITS-1.
  - Equivalent words: word1 = ~((1<<min(n,BITS))-1); word2 = ~((1<<max(n-BITS,0))-1), both truncated to BITS.
- FSM states and transitions:
  - IDLE: o_ready=1, o_ser_valid=0. Goes to SHIFT on accept, with bit index k=0.
  - SHIFT: o_ser_valid=1, o_ser_data=pattern[k], o_ser_last=(k==2*BITS-1).
  - In SHIFT, k increments on each cycle with i_ser_ready=1.
  - On the last handshake the FSM returns to IDLE.
- Backpressure: while i_ser_ready=0, o_ser_data, o_ser_last and k hold.
- o_clamp holds its value until the next accept.
- Requests arriving while busy are not accepted; the requester holds i_valid.

## Timing
- Reset values: o_ready=1, o_ser_valid=0, o_ser_data=0, o_ser_last=0, o_clamp=0, o_busy=0, state IDLE, k=0.
- Accept at edge t: first bit valid after edge t, i.e. latency 1 cycle.
- Minimum transaction length is 2*BITS+1 cycles.
  - The last handshake at edge t+2*BITS; o_ready=1 after that edge.
  - No same-cycle re-accept.
- o_ser_data is registered, with no combinational path from i_ser_ready to the outputs.
- Reset mid-stream: all outputs return to reset values immediately.
  - No o_ser_last is produced.
  - The aborted transaction is not resumed.
- n=0 gives an all-ones stream; n=2*BITS gives an all-zeros stream.

## Configuration
- ZERO_COUNT_GEN_PARALLEL_EN defined: adds the following outputs.
  - o_word1 (BITS) and o_word2 (BITS): loaded after the accept edge, held until the next accept, reset to all ones.
  - o_word_valid (1): one-cycle pulse after the accept edge, reset 0.
- Not defined: these ports and their registers are absent. Serial behaviour is identical either way.

## Structure
- Package zero_count_gen_pkg holds:
  - typedef enum logic {ST_IDLE, ST_SHIFT} zcg_state_t;
  - a stream-length function returning 2*BITS;
  - a thermometer mask function therm(len, width) returning the low-len zeros, ones-elsewhere word.
- One sub-module, zero_count_gen_therm: combinational n to {word2, word1} pattern. The top selects bit k from it or loads it into the shift source.

## Test plan
All scenarios use BITS=3.
- Count 0, i_ser_ready=1: stream 1,1,1,1,1,1; o_ser_last on 6th bit; o_clamp=0; o_ready back 7 cycles after accept.
- Count 4: stream 0,0,0,0,1,1; with macro on, o_word1=3'b000, o_word2=3'b110, o_word_valid single pulse.
- Count 7: o_clamp=1; stream six zeros; with macro on, both words 3'b000.
- Count 2 with i_ser_ready toggled 1,0,0,1,...: each bit held during stalls; sequence 0,0,1,1,1,1 delivered exactly once.
- i_rst_n low at bit 3 of count 5: outputs at reset values immediately; new request count 1 then yields 0,1,1,1,1,1.
- Back-to-back: i_valid held high with counts 6 then 1: second accept exactly one cycle after first o_ser_last handshake; o_clamp=0 for both.
